// File: rtl/ss_wbmem.sv
// ss_wbmem: Wishbone responder modelling 64-bit host memory with wait states, retry and error injection
module ss_wbmem #(
  parameter int AW = 10,
  parameter int WAIT = 1,
  parameter int RTY_EVERY = 0,
  parameter logic [31:0] ERR_BASE = 32'h0,
  parameter logic [31:0] ERR_MASK = 32'h0
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        wbm_cyc,
  input  logic        wbm_stb,
  input  logic        wbm_we,
  input  logic        wbm_pref,
  input  logic        wbm_cab,
  input  logic [3:0]  wbm_sel,
  input  logic [31:0] wbm_adr,
  input  logic [31:0] wbm_dat_i,
  input  logic [31:0] wbm_dat64_i,
  output logic [31:0] wbm_dat_o,
  output logic [31:0] wbm_dat64_o,
  output logic        wbm_ack,
  output logic        wbm_rty,
  output logic        wbm_err,
  output logic [15:0] beat_cnt
);
  typedef enum logic [2:0] {IDLE, WT, XFER, RETRY, ERROR} st_t;
  localparam logic [3:0] WL = 4'(WAIT);
  localparam logic [15:0] RE = 16'(RTY_EVERY);
  st_t st, st_n;
  logic [63:0] mem [2**AW];
  logic [3:0] wcnt;
  logic [15:0] bcnt;
  logic [AW-1:0] idx;
  logic req, bad, bad_nx, unused;
  function automatic logic is_bad(input logic [31:0] a);
    return ((a >> (AW + 3)) != 32'd0) || (ERR_MASK != 32'd0 && (a & ERR_MASK) == (ERR_BASE & ERR_MASK));
  endfunction
  assign unused = ^{wbm_pref, wbm_sel, wbm_adr[2:0]};
  assign req = wbm_cyc & wbm_stb;
  assign idx = wbm_adr[AW+2:3];
  assign bad = is_bad(wbm_adr);
  assign bad_nx = is_bad(wbm_adr + 32'd8);
  assign wbm_dat_o = mem[idx][31:0];
  assign wbm_dat64_o = mem[idx][63:32];
  assign wbm_ack = (st == XFER) & req;
  assign wbm_rty = (st == RETRY) & req;
  assign wbm_err = (st == ERROR) & req;
  always_comb begin
    st_n = st;
    case (st)
      IDLE:  st_n = !req ? IDLE : WL != 4'd0 ? WT : bad ? ERROR : XFER;
      WT:    st_n = !req ? IDLE : wcnt > 4'd1 ? WT : bad ? ERROR : XFER;
      XFER:  st_n = !req || !wbm_cab ? IDLE : RE != 16'd0 && bcnt + 16'd1 == RE ? RETRY : bad_nx ? ERROR : XFER;
      RETRY: st_n = IDLE;
      ERROR: st_n = wbm_cyc ? ERROR : IDLE;
      default: st_n = IDLE;
    endcase
  end
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      st <= IDLE;
      wcnt <= 4'd0;
      bcnt <= 16'd0;
      beat_cnt <= 16'd0;
    end else begin
      st <= st_n;
      wcnt <= st == IDLE ? WL : st == WT ? wcnt - 4'd1 : wcnt;
      bcnt <= st == IDLE || st == RETRY ? 16'd0 : wbm_ack ? bcnt + 16'd1 : bcnt;
      beat_cnt <= beat_cnt + {15'd0, wbm_ack};
    end
  end
  // memory ignores reset so a write acked in the reset cycle still lands
  always_ff @(posedge wb_clk_i)
    if (wbm_ack && wbm_we) mem[idx] <= {wbm_dat64_i, wbm_dat_i};
endmodule
